// File: rtl/cpu_defs_pkg.sv
// Shared constants for the MIPS pipeline front end.
// Word size and the canonical NOP/zero words used when bubbling pipeline registers.
package cpu_defs;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_INST   = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES = 32'd4;
endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter, instruction-memory enable and the branch redirect held across stalls.
// A redirect arriving while IF is stalled is parked in pend_* and applied on release.
module pc_reg #(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic [31:0] pc,
  output logic        ce
);
  import cpu_defs::*;

  logic        pend_valid;
  logic [31:0] pend_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      ce          <= 1'b0;
      pend_valid  <= 1'b0;
      pend_target <= ZERO_WORD;
    end else begin
      ce <= 1'b1;
      // pc is frozen until the memory is enabled, so RESET_PC is always fetched first
      if (ce) begin
        if (flush) begin
          pc         <= flush_pc;
          pend_valid <= 1'b0;
        end else if (stall_if) begin
          if (branch_flag) begin
            pend_valid  <= 1'b1;
            pend_target <= branch_target;
          end
        end else if (pend_valid) begin
          pc         <= pend_target;
          pend_valid <= 1'b0;
        end else if (branch_flag) begin
          pc <= branch_target;
        end else begin
          pc <= pc + WORD_BYTES;
        end
      end
    end
  end
endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: drives the instruction memory and captures its word into IF/ID.
// The delay-slot word fetched alongside a taken branch is kept, never squashed.
module if_stage #(
  parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC,
  parameter logic [31:0] NOP_INST = cpu_defs::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if,
  input  logic        stall_id,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic [31:0] inst_rom_data,
  output logic        inst_rom_ce,
  output logic [31:0] inst_rom_addr,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
  output logic        id_excp_adel
);
  import cpu_defs::*;

  logic [31:0] pc;
  logic        ce;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .stall_if      (stall_if),
    .branch_flag   (branch_flag),
    .branch_target (branch_target),
    .flush         (flush),
    .flush_pc      (flush_pc),
    .pc            (pc),
    .ce            (ce)
  );

  assign inst_rom_addr = pc;
  assign inst_rom_ce   = ce;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      id_pc        <= ZERO_WORD;
      id_inst      <= NOP_INST;
      id_valid     <= 1'b0;
      id_excp_adel <= 1'b0;
    end else if (!stall_id) begin
      if (stall_if || !ce) begin
        id_pc        <= ZERO_WORD;
        id_inst      <= NOP_INST;
        id_valid     <= 1'b0;
        id_excp_adel <= 1'b0;
      end else begin
        // a misaligned fetch still occupies the slot so the AdEL reaches ID with its PC
        id_pc        <= pc;
        id_valid     <= 1'b1;
        id_excp_adel <= (pc[1:0] != 2'b00);
        id_inst      <= (pc[1:0] == 2'b00) ? inst_rom_data : NOP_INST;
      end
    end
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline, directly upstream of the instruction memory.
- Holds the PC and drives the memory's chip-enable and byte address.
- Memory returns the word combinationally in the same cycle; this block captures it into the IF/ID pipeline register.
- Handles sequential fetch, branch/jump redirect with one architectural delay slot, pipeline stalls, and exception/flush redirect.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0000, word injected into IF/ID on bubble or flush (sll $0,$0,0).

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_if  in  1  hold PC; IF/ID behaviour below.
- stall_id  in  1  hold IF/ID register contents.
- branch_flag  in  1  from ID: the instruction in ID is a taken branch/jump.
- branch_target  in  32  redirect address, valid when branch_flag=1.
- flush  in  1  from CP0/exception unit: discard fetch and redirect.
- flush_pc  in  32  handler or EPC address, valid when flush=1.
- inst_rom_data  in  32  instruction word from the instruction memory, valid in the same cycle as the address.
- inst_rom_ce  out  1  instruction memory chip-enable (registered).
- inst_rom_addr  out  32  byte address to the instruction memory; equals pc.
- id_pc  out  32  PC of the instruction held in IF/ID.
- id_inst  out  32  instruction held in IF/ID.
- id_valid  out  1  IF/ID holds a real instruction.
- id_excp_adel  out  1  IF/ID instruction came from a misaligned PC (AdEL on fetch).

Behaviour:
- Reset (rst=1 at an edge):
  - pc=RESET_PC, inst_rom_ce=0, pend_valid=0.
  - id_pc=0, id_inst=NOP_INST, id_valid=0, id_excp_adel=0.
  - Reset mid-operation discards any pending branch and the IF/ID contents.
- inst_rom_ce:
  - Set to 1 at the first edge with rst=0, then held at 1.
  - pc does not change while inst_rom_ce=0, so the first fetch is always RESET_PC.
- Next-PC priority, evaluated only when inst_rom_ce=1:
  - 1. flush: pc<=flush_pc; pend_valid<=0.
  - 2. stall_if: pc holds. If branch_flag=1, pend_valid<=1 and pend_target<=branch_target. The redirect is not lost.
  - 3. pend_valid: pc<=pend_target; pend_valid<=0.
  - 4. branch_flag: pc<=branch_target.
  - 5. Otherwise pc<=pc+4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Delay slot:
  - branch_flag is asserted while the branch is in ID. IF is fetching the delay-slot word in that same cycle.
  - The delay-slot word is captured into IF/ID normally and is never squashed by branch_flag.
- IF/ID register priority:
  - 1. flush: bubble (id_inst=NOP_INST, id_valid=0, id_excp_adel=0, id_pc=0).
  - 2. stall_id: hold all fields.
  - 3. stall_if (with stall_id=0): bubble.
  - 4. inst_rom_ce=0: bubble.
  - 5. Otherwise id_pc<=pc and id_valid<=1:
    - pc[1:0]==0: id_inst<=inst_rom_data, id_excp_adel<=0.
    - pc[1:0]!=0: id_inst<=NOP_INST, id_excp_adel<=1.
  - A misaligned PC continues to increment by 4 until a flush arrives.
- Simultaneous events:
  - flush and branch_flag together: flush wins; the branch is dropped.
  - flush and stall_if together: flush wins.
  - branch_flag during stall_if with a pend already held: the newer target overwrites it. ID holds the same branch while stalled, so the value is identical.
- Latency:
  - Redirect takes effect one cycle after branch_flag or flush is sampled.
  - Instruction at address A appears on id_inst one cycle after pc=A.

Decomposition:
- Shared package cpu_defs holds: RESET_PC, NOP_INST, ZERO_WORD, WORD_BYTES=4.
- Sub-module pc_reg contains pc, inst_rom_ce, the pend register and the next-PC mux.
- The IF/ID register stays in if_stage.

Test Plan:
- Reset release with memory preloaded: addr 0, 4, 8 on consecutive cycles. id_inst follows one cycle later (0x0000f025, 0x241d1000, 0x8f990008). id_valid rises on the second edge after reset.
- Branch at pc 0x0C, branch_flag=1 with target 0x218 while pc=0x10: delay slot 0x10 is captured with id_valid=1. Next pc=0x218.
- Hold stall_if=stall_id=1 for 3 cycles with pc=0x24: pc and IF/ID are frozen. Then stall_if=1, stall_id=0 for one cycle: id_valid=0, id_inst=0.
- branch_flag=1 to 0x80 during stall_if=1, then stall released: pc goes directly to 0x80 with no pc+4 step. A simultaneous flush to 0x180 instead yields pc=0x180 and bubbles IF/ID.
- flush_pc=0x102: id_excp_adel=1, id_inst=0. pc=0xFFFFFFFC free-running: next pc=0x0.
- rst asserted while pend_valid=1: after release, the first fetch is at 0 and the pending target is never used.
